seq_gen_arbiter: RTL and testbench
==================================

Name: seq_gen_arbiter

Overview:
- Shares one sequence_gen instance between NREQ independent requesters.
- Arbitrates requests round-robin and sequences the generator's load/mode/order/data_in inputs.
- Waits for done, overflow or error, or a timeout, then returns the result and status to the winning requester and clears the generator.
- Sits between the requester clients and sequence_gen in top_hdl; seq_gen_chkr continues to monitor the generator-side signals.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_SLACK, 4, extra cycles beyond order+2 before a calculation is declared timed out (0..255).
- RRW, 3, width of the grant index; must satisfy 2**RRW >= NREQ.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; bit i belongs to requester i.
- req_mode  in  NREQ  per-requester mode: 0 = fibonacci, 1 = triangle.
- req_order  in  16*NREQ  per-requester order, requester i at [16i+15:16i].
- req_data  in  64*NREQ  per-requester data_in, requester i at [64i+63:64i].
- grant  out  NREQ  one-hot, one-cycle pulse to the winning requester.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accepts.
- rsp_id  out  RRW  index of the requester that owns the response.
- rsp_data  out  64  captured data_out.
- rsp_status  out  2  00 = OK, 01 = OVERFLOW, 10 = ERROR, 11 = TIMEOUT.
- load, fibonacci, triangle, clear  out  1  drive sequence_gen.
- order  out  16  drives sequence_gen.
- data_in  out  64  drives sequence_gen.
- done, overflow, error  in  1  from sequence_gen.
- data_out  in  64  from sequence_gen.
- proto_err  out  1  sticky; set on a generator result seen outside WAIT.

Behaviour:
- Reset (reset_n=0), applied asynchronously at any time including mid-operation:
  - State goes to IDLE and all outputs go to 0.
  - The round-robin pointer is set so requester 0 has highest priority.
  - Latched request registers and the cycle counter are cleared.
- FSM states: IDLE, LOAD1, LOAD2, WAIT, RESP, CLR.
- IDLE:
  - If req != 0 at posedge k, pick the first set bit scanning upward from (last_winner+1) mod NREQ, wrapping.
  - Latch that requester's mode, order and data into internal registers; record the winner; go to LOAD1.
  - If req == 0, stay in IDLE.
- LOAD1 (cycle k+1): grant[winner]=1, load=1.
- LOAD2 (cycle k+2): load=1, grant=0.
- Outputs in LOAD1 and LOAD2:
  - fibonacci = ~mode and triangle = mode, so exactly one is set.
  - order and data_in are driven from the latched values and are never X/Z.
  - In LOAD2, go to WAIT.
- Generator inputs outside LOAD1/LOAD2: load, fibonacci and triangle are 0; order and data_in are driven to 0, never X.
- WAIT:
  - A 17-bit counter starts at 1 on the first WAIT cycle and increments each cycle.
  - Sampled each posedge with priority error > overflow > done:
    - error: status ERROR.
    - overflow: status OVERFLOW.
    - done: status OK.
  - In all three cases, capture data_out into rsp_data and go to RESP.
  - If none is seen and the counter equals order+2+TIMEOUT_SLACK: status TIMEOUT, rsp_data = 0, go to RESP.
- RESP:
  - rsp_valid=1 with rsp_id, rsp_data and rsp_status held stable.
  - On the first posedge with rsp_ready=1, drop rsp_valid and go to CLR.
  - rsp_ready while rsp_valid=0 is ignored.
- CLR: clear=1 for exactly one cycle; go to IDLE. The next arbitration can occur on the following posedge.
- Request rules:
  - A requester holds req until it sees grant. After grant, its req is ignored until IDLE.
  - A requester still holding req after grant is simply re-arbitrated later, behind the other pending requesters.
  - Dropping req before grant withdraws the request.
  - Requests arriving in any state other than IDLE wait; they are not lost while req is held.
- proto_err: set if done, overflow or error is 1 in IDLE, LOAD1, LOAD2 or CLR. It stays set until reset.
- Throughput: at most one calculation in flight. Minimum turnaround from req to next possible grant is 2 + wait + 1 + RESP hold + 1 cycles.

Test Plan:
- Single request: reset, then req[0]=1, mode=0, order=5, data=1.
  - grant=0001 one cycle later; load high for 2 cycles; fibonacci=1, triangle=0.
  - Model asserts done at 7 cycles with data_out=8: rsp_valid, rsp_id=0, rsp_status=00, rsp_data=8; clear pulses once after rsp_ready.
- Round-robin: req=1011 held continuously.
  - Grant order is 0001, 0010, 1000, 0001.
  - Requester 2 never granted while req[2]=0.
- Simultaneous results: model asserts overflow and done in the same WAIT cycle with data_out=all 1's → rsp_status=01. A variant asserting error+done → rsp_status=10.
- Timeout: order=3, TIMEOUT_SLACK=4, model never responds → rsp_status=11 and rsp_data=0 after exactly 9 WAIT cycles; then clear pulses.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid and the payload stay stable and no new grant is issued; release → CLR, then the next grant.
- Reset mid-WAIT plus spurious done:
  - reset_n=0 during WAIT → all outputs 0 immediately (asynchronous); after release the first grant goes to requester 0.
  - done pulsed in IDLE → proto_err=1 and it stays 1 until reset.

Source files
------------

// File: rtl/seq_gen_arbiter.sv
// Round-robin front end sharing one sequence_gen between NREQ requesters: sequences the
// load phase, waits for a result or timeout, hands the response back and clears the generator.
module seq_gen_arbiter #(
  parameter int NREQ          = 4,
  parameter int TIMEOUT_SLACK = 4,
  parameter int RRW           = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [16*NREQ-1:0]   req_order,
  input  logic [64*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RRW-1:0]       rsp_id,
  output logic [63:0]          rsp_data,
  output logic [1:0]           rsp_status,
  output logic                 load,
  output logic                 fibonacci,
  output logic                 triangle,
  output logic                 clear,
  output logic [15:0]          order,
  output logic [63:0]          data_in,
  input  logic                 done,
  input  logic                 overflow,
  input  logic                 error,
  input  logic [63:0]          data_out,
  output logic                 proto_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_CLR   = 3'd5
  } state_t;

  localparam logic [1:0]     ST_OK    = 2'b00;
  localparam logic [1:0]     ST_OVF   = 2'b01;
  localparam logic [1:0]     ST_ERR   = 2'b10;
  localparam logic [1:0]     ST_TMO   = 2'b11;
  localparam logic [RRW-1:0] LAST_RST = RRW'(NREQ - 1);
  localparam logic [16:0]    SLACK    = 17'(TIMEOUT_SLACK);

  state_t          r_state, w_next;
  logic [RRW-1:0]  r_winner, w_winner_n, w_pick, w_rsp_id_n;
  logic            w_found, w_sel_mode, r_mode, w_mode_n;
  logic [15:0]     w_sel_order, r_order, w_order_n;
  logic [63:0]     w_sel_data, r_data, w_data_n, w_rsp_data_n;
  logic [16:0]     r_cnt, w_cnt_n, w_limit;
  logic [1:0]      w_rsp_status_n;
  logic [NREQ-1:0] w_onehot;
  logic            w_loading, w_result, w_off_wait;

  assign w_limit    = {1'b0, r_order} + 17'd2 + SLACK;
  assign w_loading  = (w_next == S_LOAD1) || (w_next == S_LOAD2);
  assign w_result   = done | overflow | error;
  assign w_off_wait = (r_state == S_IDLE) || (r_state == S_LOAD1) ||
                      (r_state == S_LOAD2) || (r_state == S_CLR);

  // Round-robin pick: scan above the last winner first, then wrap to the low slots.
  always_comb begin
    w_found = 1'b0;
    w_pick  = {RRW{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && req[j] && (j > int'(r_winner))) begin
        w_found = 1'b1;
        w_pick  = RRW'(j);
      end else begin
        w_found = w_found;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && req[j] && (j <= int'(r_winner))) begin
        w_found = 1'b1;
        w_pick  = RRW'(j);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Operand mux for the pick, plus the one-hot grant for whoever will hold the generator.
  always_comb begin
    w_sel_mode  = 1'b0;
    w_sel_order = 16'd0;
    w_sel_data  = 64'd0;
    w_onehot    = {NREQ{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      if (w_pick == RRW'(j)) begin
        w_sel_mode  = req_mode[j];
        w_sel_order = req_order[16*j +: 16];
        w_sel_data  = req_data[64*j +: 64];
      end else begin
        w_sel_mode  = w_sel_mode;
      end
      w_onehot[j] = (w_winner_n == RRW'(j));
    end
  end

  // Next-state and datapath updates; the result priority is error > overflow > done > timeout.
  always_comb begin
    w_next         = r_state;
    w_winner_n     = r_winner;
    w_mode_n       = r_mode;
    w_order_n      = r_order;
    w_data_n       = r_data;
    w_cnt_n        = r_cnt;
    w_rsp_id_n     = rsp_id;
    w_rsp_data_n   = rsp_data;
    w_rsp_status_n = rsp_status;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next     = S_LOAD1;
          w_winner_n = w_pick;
          w_mode_n   = w_sel_mode;
          w_order_n  = w_sel_order;
          w_data_n   = w_sel_data;
        end else begin
          w_next     = S_IDLE;
        end
      end
      S_LOAD1: w_next = S_LOAD2;
      S_LOAD2: begin
        w_next  = S_WAIT;
        w_cnt_n = 17'd1;
      end
      S_WAIT: begin
        w_rsp_id_n = r_winner;
        if (error) begin
          w_next = S_RESP; w_rsp_status_n = ST_ERR; w_rsp_data_n = data_out;
        end else if (overflow) begin
          w_next = S_RESP; w_rsp_status_n = ST_OVF; w_rsp_data_n = data_out;
        end else if (done) begin
          w_next = S_RESP; w_rsp_status_n = ST_OK;  w_rsp_data_n = data_out;
        end else if (r_cnt == w_limit) begin
          w_next = S_RESP; w_rsp_status_n = ST_TMO; w_rsp_data_n = 64'd0;
        end else begin
          w_cnt_n = r_cnt + 17'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_CLR;
        end else begin
          w_next = S_RESP;
        end
      end
      S_CLR: begin
        w_next  = S_IDLE;
        w_cnt_n = 17'd0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, latched request and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_winner   <= LAST_RST;
      r_mode     <= 1'b0;
      r_order    <= 16'd0;
      r_data     <= 64'd0;
      r_cnt      <= 17'd0;
      grant      <= {NREQ{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_id     <= {RRW{1'b0}};
      rsp_data   <= 64'd0;
      rsp_status <= 2'b00;
      load       <= 1'b0;
      fibonacci  <= 1'b0;
      triangle   <= 1'b0;
      clear      <= 1'b0;
      order      <= 16'd0;
      data_in    <= 64'd0;
      proto_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_winner   <= w_winner_n;
      r_mode     <= w_mode_n;
      r_order    <= w_order_n;
      r_data     <= w_data_n;
      r_cnt      <= w_cnt_n;
      grant      <= (w_next == S_LOAD1) ? w_onehot : {NREQ{1'b0}};
      rsp_valid  <= (w_next == S_RESP);
      rsp_id     <= w_rsp_id_n;
      rsp_data   <= w_rsp_data_n;
      rsp_status <= w_rsp_status_n;
      load       <= w_loading;
      fibonacci  <= w_loading & ~w_mode_n;
      triangle   <= w_loading & w_mode_n;
      clear      <= (w_next == S_CLR);
      order      <= w_loading ? w_order_n : 16'd0;
      data_in    <= w_loading ? w_data_n : 64'd0;
      proto_err  <= proto_err | (w_result & w_off_wait);
    end
  end

endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Scoreboard bench for seq_gen_arbiter: the bench plays the requesters and the sequence_gen,
// queues the expected response per transaction and compares it when rsp_valid appears.
`timescale 1ns/1ps
module tb_seq_gen_arbiter;
  localparam int NREQ  = 4;
  localparam int SLACK = 4;
  localparam int RRW   = 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NREQ-1:0]    req = '0, req_mode = '0;
  logic [16*NREQ-1:0] req_order = '0;
  logic [64*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]    grant;
  logic               rsp_valid, rsp_ready = 1'b0;
  logic [RRW-1:0]     rsp_id;
  logic [63:0]        rsp_data;
  logic [1:0]         rsp_status;
  logic               load, fibonacci, triangle, clear, proto_err;
  logic [15:0]        order;
  logic [63:0]        data_in;
  logic               done = 1'b0, overflow = 1'b0, error = 1'b0;
  logic [63:0]        data_out = '0;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [RRW-1:0] id;
    logic [1:0]     st;
    logic [63:0]    d;
  } rsp_t;
  rsp_t sb_q[$];

  always #5 clk = ~clk;

  seq_gen_arbiter #(.NREQ(NREQ), .TIMEOUT_SLACK(SLACK), .RRW(RRW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_mode(req_mode), .req_order(req_order),
    .req_data(req_data), .grant(grant), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_status(rsp_status), .load(load),
    .fibonacci(fibonacci), .triangle(triangle), .clear(clear), .order(order),
    .data_in(data_in), .done(done), .overflow(overflow), .error(error),
    .data_out(data_out), .proto_err(proto_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic m, input logic [15:0] o, input logic [63:0] d);
    req_mode[i]            = m;
    req_order[16*i +: 16]  = o;
    req_data[64*i +: 64]   = d;
    req[i]                 = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_grant"}, grant, 64'd0);
    check_val({tag, "_load"}, {load, fibonacci, triangle, clear}, 64'd0);
    check_val({tag, "_rsp_valid"}, rsp_valid, 64'd0);
    check_val({tag, "_rsp_id"}, rsp_id, 64'd0);
    check_val({tag, "_rsp_data"}, rsp_data, 64'd0);
    check_val({tag, "_rsp_status"}, rsp_status, 64'd0);
    check_val({tag, "_order"}, order, 64'd0);
    check_val({tag, "_data_in"}, data_in, 64'd0);
    check_val({tag, "_proto_err"}, proto_err, 64'd0);
  endtask

  // deo = {done, overflow, error} driven in WAIT cycle resp_at; resp_at == 0 never responds.
  task automatic do_txn(input int id, input logic m, input logic [15:0] o, input logic [63:0] d,
                        input int resp_at, input logic [2:0] deo, input logic [63:0] dout,
                        input int hold, input logic drop, input logic [1:0] exp_st,
                        input logic [63:0] exp_d);
    rsp_t            e, got;
    logic [NREQ-1:0] gexp;
    logic            fib_e;
    int              waited, exp_wait;
    e.id  = RRW'(id);
    e.st  = exp_st;
    e.d   = exp_d;
    sb_q.push_back(e);
    gexp     = '0;
    gexp[id] = 1'b1;
    fib_e    = ~m;
    exp_wait = (resp_at == 0) ? int'(o) + 2 + SLACK : resp_at;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check_val("grant", grant, gexp);
    check_val("load1", load, 64'd1);
    check_val("fibonacci", fibonacci, fib_e);
    check_val("triangle", triangle, m);
    check_val("order", order, o);
    check_val("data_in", data_in, d);
    if (drop) req[id] = 1'b0;
    @(negedge clk);
    check_val("load2", load, 64'd1);
    check_val("grant_pulse", grant, 64'd0);
    waited   = -1;
    data_out = dout;
    for (int w = 1; w <= 300; w++) begin
      @(negedge clk);
      {done, overflow, error} = 3'b000;
      if (w == 1) check_val("load_off", {load, order}, 64'd0);
      if (rsp_valid) begin
        waited = w - 1;
        break;
      end
      if (w == resp_at) {done, overflow, error} = deo;
    end
    check_val("wait_cycles", waited, exp_wait);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check_val("rsp_id", rsp_id, got.id);
      check_val("rsp_status", rsp_status, got.st);
      check_val("rsp_data", rsp_data, got.d);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_val("bp_valid", rsp_valid, 64'd1);
        check_val("bp_payload", {rsp_id, rsp_status, rsp_data}, {got.id, got.st, got.d});
        check_val("bp_no_grant", {grant, clear}, 64'd0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("clr_valid", rsp_valid, 64'd0);
    check_val("clr_pulse", clear, 64'd1);
    @(negedge clk);
    check_val("clr_end", clear, 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    set_req(0, 1'b0, 16'd5, 64'd1);
    do_txn(0, 1'b0, 16'd5, 64'd1, 7, 3'b100, 64'd8, 0, 1'b1, 2'b00, 64'd8);

    set_req(2, 1'b1, 16'd10, 64'h55);
    do_txn(2, 1'b1, 16'd10, 64'h55, 3, 3'b110, {64{1'b1}}, 0, 1'b1, 2'b01, {64{1'b1}});

    set_req(1, 1'b0, 16'd20, 64'h77);
    do_txn(1, 1'b0, 16'd20, 64'h77, 5, 3'b101, 64'h1234, 0, 1'b1, 2'b10, 64'h1234);

    // 1011 held: pointer sits at 1, so 3 wins first (timeout + backpressure), then 0,1,3,0.
    set_req(0, 1'b0, 16'd4, 64'hA);
    set_req(1, 1'b1, 16'd6, 64'hB);
    set_req(3, 1'b1, 16'd3, 64'h9);
    do_txn(3, 1'b1, 16'd3, 64'h9, 0, 3'b100, 64'hFFFF0000AAAA5555, 10, 1'b0, 2'b11, 64'd0);
    do_txn(0, 1'b0, 16'd4, 64'hA, 2, 3'b100, 64'hA0, 0, 1'b0, 2'b00, 64'hA0);
    do_txn(1, 1'b1, 16'd6, 64'hB, 1, 3'b010, 64'hB1, 0, 1'b0, 2'b01, 64'hB1);
    do_txn(3, 1'b1, 16'd3, 64'h9, 4, 3'b100, 64'h93, 0, 1'b0, 2'b00, 64'h93);
    do_txn(0, 1'b0, 16'd4, 64'hA, 3, 3'b001, 64'hA3, 0, 1'b0, 2'b10, 64'hA3);
    req = '0;
    @(negedge clk);

    // Reset mid-WAIT: without it, 1101 after winner 1 would go to 2.
    set_req(1, 1'b0, 16'd100, 64'h42);
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check_val("mid_grant", grant, 64'b0010);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    set_req(0, 1'b1, 16'd7, 64'h3);
    set_req(2, 1'b0, 16'd8, 64'h4);
    set_req(3, 1'b0, 16'd9, 64'h5);
    repeat (3) begin
      @(negedge clk);
      check_val("wait_no_grant", grant, 64'd0);
    end
    check_val("pre_reset_id", rsp_id, 64'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(0, 1'b1, 16'd7, 64'h3, 2, 3'b100, 64'hCAFE, 0, 1'b1, 2'b00, 64'hCAFE);
    req = '0;
    @(negedge clk);

    // Spurious done in IDLE must set the sticky proto_err.
    check_val("proto_err_clean", proto_err, 64'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_val("proto_err_set", proto_err, 64'd1);
    repeat (4) begin
      @(negedge clk);
      check_val("proto_err_sticky", proto_err, 64'd1);
    end
    check_val("idle_no_grant", grant, 64'd0);
    reset_n = 1'b0;
    #1 check_val("proto_err_reset", proto_err, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
